gsim_matvec: RTL and testbench

- Forward-model checker that sits on the output end of the GSIM solver stream.
- Consumes the 16 solved x values (Q16.16, as GSIM emits them on out_valid/x_out) and recomputes b = A·x.
- A is the same 16×16 banded matrix GSIM inverts: diagonal 20, ±1 off-diagonal −13, ±2 off-diagonal +6, ±3 off-diagonal −1.
- Emits the 16 reconstructed b words in GSIM input format (16-bit integer) with a valid strobe, so a bench or the downstream path can compare them against the original b_in stream.

---
 rtl/gsim_matvec_if.sv | 50 +++++
 rtl/gsim_matvec.sv | 166 ++++++++++++++++
 tb/tb_gsim_matvec.sv | 174 +++++++++++++++++
 3 files changed

// File: rtl/gsim_matvec_if.sv
// gsim_matvec_if: handshake/data bundle for the gsim_matvec forward-model checker.
//   x_valid / x_in : solution stream into the checker (Q16.16, index order 0..LEN-1)
//   busy           : checker is replaying b and ignores x_valid
//   b_valid / b_out: reconstructed b stream (16-bit signed, index order 0..LEN-1)
//   sat_flag       : sticky clamp indicator, only with GSIM_MATVEC_SAT_EN defined
// The slave modport is the checker side; the master modport is the producer/consumer side.
interface gsim_matvec_if;
  logic        x_valid;
  logic [31:0] x_in;
  logic        busy;
  logic        b_valid;
  logic [15:0] b_out;
`ifdef GSIM_MATVEC_SAT_EN
  logic        sat_flag;

  modport slave (
    input  x_valid,
    input  x_in,
    output busy,
    output b_valid,
    output b_out,
    output sat_flag
  );

  modport master (
    output x_valid,
    output x_in,
    input  busy,
    input  b_valid,
    input  b_out,
    input  sat_flag
  );
`else
  modport slave (
    input  x_valid,
    input  x_in,
    output busy,
    output b_valid,
    output b_out
  );

  modport master (
    output x_valid,
    output x_in,
    input  busy,
    input  b_valid,
    input  b_out
  );
`endif
endinterface

// File: rtl/gsim_matvec.sv
// gsim_matvec: forward-model checker for the GSIM solver output.
// Collects LEN solved x words (Q16.16), then replays b = A*x one word per cycle, where A is the
// banded matrix GSIM inverts: diag 20, +-1 -13, +-2 +6, +-3 -1. Results are rounded half toward
// +inf at FRAC and narrowed to 16 bits.
// Ports:
//   clk    : clock, all state on the rising edge
//   reset  : asynchronous active-low reset
//   mv_io  : gsim_matvec_if.slave (x_valid/x_in in, busy/b_valid/b_out out, sat_flag if enabled)
// Build option: define GSIM_MATVEC_SAT_EN to clamp results to 16 bits and expose a sticky
// sat_flag; otherwise results wrap in two's complement and sat_flag does not exist.
module gsim_matvec #(
  parameter int unsigned LEN  = 16,
  parameter int unsigned FRAC = 16
) (
  input logic          clk,
  input logic          reset,
  gsim_matvec_if.slave mv_io
);

  localparam int unsigned     IdxW    = (LEN > 1) ? $clog2(LEN) : 1;
  localparam logic [IdxW-1:0] LastIdx = IdxW'(LEN - 1);
  localparam logic signed [39:0] RndHalf = 40'sd1 <<< (FRAC - 1);

  // StDone is the cycle b_{LEN-1} is on the bus; busy stays high so no x is taken yet.
  typedef enum logic [1:0] {StCollect, StRun, StDone} state_e;

  state_e          state_q, state_d;
  logic [IdxW-1:0] idx_q, idx_d;
  logic            bvalid_q, bvalid_d;
  logic [15:0]     bout_q, bout_d;
  logic            xbuf_we;
  logic [31:0]     xbuf_q [LEN];

  logic signed [39:0] tap [7];
  logic signed [39:0] s0, s1, s2, s3;
  logic signed [39:0] acc, rnd, r;
  logic [15:0]        b_next;
  logic               clip;

  // Buffer has no reset: every frame overwrites all LEN entries before it is read.
  always_ff @(posedge clk) begin
    if (xbuf_we) begin
      xbuf_q[idx_q] <= mv_io.x_in;
    end
  end

  // tap[d] holds x[idx+d-3], zero when the neighbour falls outside 0..LEN-1.
  always_comb begin : tap_sel
    int pos;
    pos = 0;
    for (int d = 0; d < 7; d++) begin
      pos    = int'(idx_q) + d - 3;
      tap[d] = '0;
      if (pos >= 0 && pos < int'(LEN)) begin
        tap[d] = {{8{xbuf_q[pos[IdxW-1:0]][31]}}, xbuf_q[pos[IdxW-1:0]]};
      end
    end
  end

  // Shift-add only: 20 = 16+4, 13 = 8+4+1, 6 = 4+2.
  always_comb begin
    s0  = tap[3];
    s1  = tap[2] + tap[4];
    s2  = tap[1] + tap[5];
    s3  = tap[0] + tap[6];
    acc = (s0 <<< 4) + (s0 <<< 2)
        - ((s1 <<< 3) + (s1 <<< 2) + s1)
        + ((s2 <<< 2) + (s2 <<< 1))
        - s3;
    rnd = acc + RndHalf;
    r   = rnd >>> FRAC;
  end

`ifdef GSIM_MATVEC_SAT_EN
  always_comb begin
    clip   = 1'b0;
    b_next = r[15:0];
    if (r > 40'sd32767) begin
      b_next = 16'h7fff;
      clip   = 1'b1;
    end else if (r < -40'sd32768) begin
      b_next = 16'h8000;
      clip   = 1'b1;
    end
  end
`else
  logic unused_r_hi;
  assign unused_r_hi = ^r[39:16];
  assign clip        = 1'b0;
  assign b_next      = r[15:0];
`endif

  always_comb begin
    state_d  = state_q;
    idx_d    = idx_q;
    bvalid_d = 1'b0;
    bout_d   = bout_q;
    xbuf_we  = 1'b0;
    unique case (state_q)
      StCollect: begin
        if (mv_io.x_valid) begin
          xbuf_we = 1'b1;
          if (idx_q == LastIdx) begin
            idx_d   = '0;
            state_d = StRun;
          end else begin
            idx_d = idx_q + 1'b1;
          end
        end
      end
      StRun: begin
        bvalid_d = 1'b1;
        bout_d   = b_next;
        if (idx_q == LastIdx) begin
          idx_d   = '0;
          state_d = StDone;
        end else begin
          idx_d = idx_q + 1'b1;
        end
      end
      StDone: begin
        state_d = StCollect;
      end
      default: begin
        state_d = StCollect;
        idx_d   = '0;
      end
    endcase
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q  <= StCollect;
      idx_q    <= '0;
      bvalid_q <= 1'b0;
      bout_q   <= '0;
    end else begin
      state_q  <= state_d;
      idx_q    <= idx_d;
      bvalid_q <= bvalid_d;
      bout_q   <= bout_d;
    end
  end

`ifdef GSIM_MATVEC_SAT_EN
  logic sat_q;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      sat_q <= 1'b0;
    end else if (state_q == StRun && clip) begin
      sat_q <= 1'b1;
    end
  end

  assign mv_io.sat_flag = sat_q;
`else
  logic unused_clip;
  assign unused_clip = clip;
`endif

  assign mv_io.busy    = (state_q != StCollect);
  assign mv_io.b_valid = bvalid_q;
  assign mv_io.b_out   = bout_q;

endmodule

// File: tb/tb_gsim_matvec.sv
// Scoreboard bench for gsim_matvec: expected b words are queued when a frame is issued and a
// negedge monitor pops and compares them whenever b_valid is high.
module tb_gsim_matvec;

  typedef logic [31:0] xvec_t [16];
  typedef int          vec_t  [16];

  logic clk = 1'b0;
  logic reset;
  always #5 clk = ~clk;

  gsim_matvec_if mv ();

  gsim_matvec #(
    .LEN  (16),
    .FRAC (16)
  ) dut (
    .clk   (clk),
    .reset (reset),
    .mv_io (mv.slave)
  );

  int n_cmp = 0;
  int n_bad = 0;
  int sb[$];

  task automatic check(input string name, input logic signed [31:0] act,
                       input logic signed [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0d, expected %0d", name, act, exp);
    end
  endtask

  // Monitor: compare every presented b word against the scoreboard head.
  always @(negedge clk) begin
    logic signed [31:0] v;
    int e;
    if (reset === 1'b1 && mv.b_valid === 1'b1) begin
      if (sb.size() == 0) begin
        check("b_valid with empty scoreboard", 32'(mv.b_valid), 0);
      end else begin
        e = sb.pop_front();
        v = $signed(mv.b_out);
        check("b_out", v, e);
      end
    end
  end

  task automatic run_frame(input xvec_t xs, input vec_t ex, input bit gap, input bit hold,
                           input string tag);
    foreach (ex[i]) sb.push_back(ex[i]);
    for (int i = 0; i < 16; i++) begin
      @(negedge clk);
      if (gap && i == 8) begin
        mv.x_valid = 1'b0;
        @(negedge clk);
        check({tag, " busy in gap"}, 32'(mv.busy), 0);
      end
      mv.x_valid = 1'b1;
      mv.x_in    = xs[i];
    end
    @(negedge clk);
    // Garbage offered while busy must be dropped.
    mv.x_valid = hold;
    mv.x_in    = 32'h7fff0000;
    check({tag, " busy after last word"}, 32'(mv.busy), 1);
    check({tag, " b_valid after last word"}, 32'(mv.b_valid), 0);
    for (int i = 0; i < 16; i++) begin
      @(negedge clk);
      check({tag, " b_valid in run"}, 32'(mv.b_valid), 1);
    end
    @(negedge clk);
    mv.x_valid = 1'b0;
    check({tag, " b_valid after run"}, 32'(mv.b_valid), 0);
    check({tag, " busy after run"}, 32'(mv.busy), 0);
    check({tag, " scoreboard drained"}, sb.size(), 0);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end

  initial begin
    xvec_t xz, ximp, xedge, xhalf, xbig;
    vec_t  ez, eimp, eedge, ehalf, ebig;

    xz    = '{default: 32'h0};
    ximp  = '{default: 32'h0};
    ximp[5] = 32'h00010000;
    xedge = '{default: 32'h0};
    xedge[0] = 32'h00010000;
    xhalf = '{default: 32'h00008000};
    xbig  = '{default: 32'h0};
    xbig[7] = 32'h7fff0000;

    ez    = '{default: 0};
    eimp  = '{0, 0, -1, 6, -13, 20, -13, 6, -1, 0, 0, 0, 0, 0, 0, 0};
    eedge = '{20, -13, 6, -1, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0};
    // Rows 2 and 13 lose one -1 tap: 5*0.5 = 2.5 rounds up to 3.
    ehalf = '{6, 0, 3, 2, 2, 2, 2, 2, 2, 2, 2, 2, 2, 3, 0, 6};
    ebig  = '{default: 0};
    ebig[4]  = -32767;
    ebig[10] = -32767;
`ifdef GSIM_MATVEC_SAT_EN
    ebig[5] = 32767;
    ebig[6] = -32768;
    ebig[7] = 32767;
    ebig[8] = -32768;
    ebig[9] = 32767;
`else
    ebig[5] = -6;
    ebig[6] = -32755;
    ebig[7] = -20;
    ebig[8] = -32755;
    ebig[9] = -6;
`endif

    reset      = 1'b0;
    mv.x_valid = 1'b0;
    mv.x_in    = '0;
    repeat (2) @(negedge clk);
    check("reset busy", 32'(mv.busy), 0);
    check("reset b_valid", 32'(mv.b_valid), 0);
    check("reset b_out", 32'(mv.b_out), 0);
`ifdef GSIM_MATVEC_SAT_EN
    check("reset sat_flag", 32'(mv.sat_flag), 0);
`endif
    reset = 1'b1;

    run_frame(xz, ez, 1'b0, 1'b0, "zero");
    run_frame(ximp, eimp, 1'b0, 1'b0, "impulse5");
    run_frame(xedge, eedge, 1'b1, 1'b0, "edge0");
    run_frame(xhalf, ehalf, 1'b0, 1'b1, "half");
`ifdef GSIM_MATVEC_SAT_EN
    check("sat_flag before overflow", 32'(mv.sat_flag), 0);
`endif
    run_frame(xbig, ebig, 1'b0, 1'b0, "big7");
`ifdef GSIM_MATVEC_SAT_EN
    check("sat_flag after overflow", 32'(mv.sat_flag), 1);
`endif
    run_frame(xedge, eedge, 1'b0, 1'b0, "after_hold");

    // Abort mid-run: reset lands on the 5th b_valid cycle.
    foreach (eimp[i]) sb.push_back(eimp[i]);
    for (int i = 0; i < 16; i++) begin
      @(negedge clk);
      mv.x_valid = 1'b1;
      mv.x_in    = ximp[i];
    end
    @(negedge clk);
    mv.x_valid = 1'b0;
    repeat (4) @(negedge clk);
    @(posedge clk);
    #2 reset = 1'b0;
    #1;
    check("abort b_valid", 32'(mv.b_valid), 0);
    check("abort busy", 32'(mv.busy), 0);
    check("abort b_out", 32'(mv.b_out), 0);
    check("abort words seen", sb.size(), 12);
    sb.delete();
    @(negedge clk);
    #1 reset = 1'b1;
    run_frame(xhalf, ehalf, 1'b0, 1'b0, "post_abort");

    check("final scoreboard empty", sb.size(), 0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
